// File: rtl/sdram_port_arb.sv
// sdram_port_arb
//
// Shares the single SDRAM controller command/data port between the ADC capture
// writer (write requester) and the Raspberry Pi readout engine (read requester).
// One fixed-length burst is granted at a time. Urgent capture writes win.
// Otherwise a tie goes to the side that was not served last.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   When this macro is defined, each side keeps a 3-bit count of the
//   arbitrations it lost while it was requesting. A side whose count has
//   reached MAX_LOSS wins the next arbitration, even against an urgent write.
//
// Ports
//   sys_clk, sys_rst_n    : clock, asynchronous active-low reset
//   wr_req, wr_urgent     : capture-side burst request / FIFO near full
//   wr_addr, wr_data      : capture burst start address / FIFO head word
//   wr_grant, wr_data_rd  : capture burst owns the port / FIFO pop strobe
//   rd_req, rd_addr       : readout-side burst request / start address
//   rd_grant              : readout burst owns the port
//   rd_data, rd_data_vld  : read word returned to the readout engine
//   mem_cmd_*             : burst command handshake to the SDRAM controller
//   mem_wdata, mem_wdata_rd   : write word and controller consume strobe
//   mem_rdata, mem_rdata_vld  : read word and its valid strobe from the controller
//   busy                  : high whenever the sequencer is not idle (status LED)
module sdram_port_arb #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8,
    parameter int MAX_LOSS  = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_req,
    input  logic              wr_urgent,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_grant,
    output logic              wr_data_rd,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_grant,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic              mem_cmd_vld,
    input  logic              mem_cmd_rdy,
    output logic              mem_cmd_wr,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wdata_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_vld,
    output logic              busy
);

    // Stop elaboration if a parameter is outside the range this block supports.
    if (BURST_LEN < 1 || BURST_LEN > 256 || MAX_LOSS < 1 || MAX_LOSS > 7) begin : g_bad_param
        $error("sdram_port_arb: BURST_LEN must be 1..256 and MAX_LOSS must be 1..7");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

    // The counter holds the beats already done. The final beat therefore
    // arrives when the counter equals BURST_LEN-1. This lets BURST_LEN = 256
    // fit in 8 bits.
    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    state_t            state, state_nxt;
    logic              wr_grant_nxt, rd_grant_nxt;
    logic              cmd_vld_nxt, cmd_wr_nxt;
    logic [ADDR_W-1:0] cmd_addr_nxt;
    logic [7:0]        beat_cnt, beat_cnt_nxt;
    logic              last_wr, last_wr_nxt;
    logic              pick_wr;
    logic              xfer_wr, xfer_rd, beat;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] LOSS_LIM = 3'(MAX_LOSS);
    logic [2:0] wr_loss, rd_loss;
`endif

    // Winner selection. This value is only used while the FSM is in IDLE.
    // The starve guard is evaluated last, so it overrides every other rule.
    always_comb begin
        pick_wr = 1'b0;
        if (wr_req && wr_urgent)
            pick_wr = 1'b1;
        else if (wr_req && !rd_req)
            pick_wr = 1'b1;
        else if (wr_req && rd_req)
            pick_wr = !last_wr;
`ifdef ARB_STARVE_GUARD_EN
        if (wr_req && wr_loss >= LOSS_LIM)
            pick_wr = 1'b1;
        else if (rd_req && rd_loss >= LOSS_LIM)
            pick_wr = 1'b0;
`endif
    end

    // Data-path steering. A beat counts only inside XFER. This blocks stray
    // controller strobes before the burst starts and after it ends.
    assign xfer_wr     = (state == XFER) && wr_grant;
    assign xfer_rd     = (state == XFER) && rd_grant;
    assign beat        = xfer_wr ? mem_wdata_rd : (xfer_rd && mem_rdata_vld);
    assign wr_data_rd  = xfer_wr && mem_wdata_rd;
    assign mem_wdata   = xfer_wr ? wr_data : '0;
    assign rd_data_vld = xfer_rd && mem_rdata_vld;
    assign rd_data     = xfer_rd ? mem_rdata : '0;

    always_comb begin
        state_nxt    = state;
        wr_grant_nxt = wr_grant;
        rd_grant_nxt = rd_grant;
        cmd_vld_nxt  = mem_cmd_vld;
        cmd_wr_nxt   = mem_cmd_wr;
        cmd_addr_nxt = mem_cmd_addr;
        beat_cnt_nxt = beat_cnt;
        last_wr_nxt  = last_wr;
        case (state)
            IDLE: begin
                if (wr_req || rd_req) begin
                    state_nxt    = ISSUE;
                    wr_grant_nxt = pick_wr;
                    rd_grant_nxt = !pick_wr;
                    cmd_vld_nxt  = 1'b1;
                    cmd_wr_nxt   = pick_wr;
                    cmd_addr_nxt = pick_wr ? wr_addr : rd_addr;
                end
            end
            ISSUE: begin
                if (mem_cmd_rdy) begin
                    state_nxt    = XFER;
                    cmd_vld_nxt  = 1'b0;
                    beat_cnt_nxt = '0;
                end
            end
            XFER: begin
                if (beat) begin
                    beat_cnt_nxt = beat_cnt + 8'd1;
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt    = IDLE;
                        wr_grant_nxt = 1'b0;
                        rd_grant_nxt = 1'b0;
                        last_wr_nxt  = mem_cmd_wr;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // busy is computed from the next state, so the registered flag always
    // matches the registered FSM state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            wr_grant     <= 1'b0;
            rd_grant     <= 1'b0;
            mem_cmd_vld  <= 1'b0;
            mem_cmd_wr   <= 1'b0;
            mem_cmd_addr <= '0;
            beat_cnt     <= '0;
            last_wr      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_grant     <= wr_grant_nxt;
            rd_grant     <= rd_grant_nxt;
            mem_cmd_vld  <= cmd_vld_nxt;
            mem_cmd_wr   <= cmd_wr_nxt;
            mem_cmd_addr <= cmd_addr_nxt;
            beat_cnt     <= beat_cnt_nxt;
            last_wr      <= last_wr_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    // Loss counters update only at an arbitration. The loser increments its
    // count only if it was also requesting. The counters saturate so they
    // cannot wrap back below the limit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_loss <= '0;
            rd_loss <= '0;
        end else if (state == IDLE && (wr_req || rd_req)) begin
            if (pick_wr) begin
                wr_loss <= '0;
                if (rd_req && rd_loss != 3'd7)
                    rd_loss <= rd_loss + 3'd1;
            end else begin
                rd_loss <= '0;
                if (wr_req && wr_loss != 3'd7)
                    wr_loss <= wr_loss + 3'd1;
            end
        end
    end
`endif

endmodule
